// File: rtl/mem_calc_if.sv
// Issue/writeback bundle of the load/store unit: micro-op in, tagged load result out.
// The master modport drives the issue signals and the slave modport drives the writeback signals.
interface mem_calc_if #(
    parameter int WIDTH_REG = 7
);
    logic                 i_valid;
    logic [6:0]           i_uop;
    logic [9:0]           i_func;
    logic [WIDTH_REG-1:0] i_addr;
    logic [31:0]          i_op1;
    logic [31:0]          i_op2;
    logic [31:0]          i_imm;
    logic [31:0]          o_data;
    logic [WIDTH_REG-1:0] o_addr;
    logic                 o_valid;

    modport master (
        output i_valid, i_uop, i_func, i_addr, i_op1, i_op2, i_imm,
        input  o_data, o_addr, o_valid
    );

    modport slave (
        input  i_valid, i_uop, i_func, i_addr, i_op1, i_op2, i_imm,
        output o_data, o_addr, o_valid
    );
endinterface

// File: rtl/mem_calc.sv
// Load/store unit over a private little-endian data memory; loads write back 1 cycle after issue.
// No backpressure: one op is accepted every cycle and back-to-back ops are fully pipelined.
module mem_calc #(
    parameter int WIDTH     = 4,
    parameter int WIDTH_REG = 7
) (
    input  logic        i_clk,
    input  logic        i_rst,
    mem_calc_if.slave   bus
);
    localparam int DEPTH = 1 << WIDTH;
    localparam logic [6:0] UOP_LOAD  = 7'b0000011;
    localparam logic [6:0] UOP_STORE = 7'b0100011;

    logic [31:0]      mem [DEPTH];
    logic [31:0]      eff;
    logic [WIDTH-1:0] widx;
    logic [1:0]       lane;
    logic [2:0]       funct3;
    logic [31:0]      rd_word;
    logic [31:0]      wr_word;
    logic [31:0]      ld_res;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic             wr_en;
    logic             ld_en;
    logic             unused_bits;

    always_comb begin
        eff     = bus.i_op1 + bus.i_imm;
        widx    = eff[WIDTH+1:2];
        lane    = eff[1:0];
        funct3  = bus.i_func[2:0];
        rd_word = mem[widx];
        ld_byte = rd_word[{lane, 3'b000} +: 8];
        ld_half = rd_word[{lane[1], 4'b0000} +: 16];
        ld_en   = bus.i_valid && (bus.i_uop == UOP_LOAD);
        wr_en   = bus.i_valid && (bus.i_uop == UOP_STORE) && (funct3 inside {3'b000, 3'b001, 3'b010});
    end

    // Store merge: untouched lanes keep the current word contents.
    always_comb begin
        wr_word = rd_word;
        case (funct3)
            3'b000:  wr_word[{lane, 3'b000} +: 8]     = bus.i_op2[7:0];
            3'b001:  wr_word[{lane[1], 4'b0000} +: 16] = bus.i_op2[15:0];
            3'b010:  wr_word                          = bus.i_op2;
            default: wr_word                          = rd_word;
        endcase
    end

    always_comb begin
        ld_res = '0;
        case (funct3)
            3'b000:  ld_res = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_res = {24'h0, ld_byte};
            3'b001:  ld_res = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_res = {16'h0, ld_half};
            3'b010:  ld_res = rd_word;
            default: ld_res = '0;
        endcase
    end

    // Address bits above the memory and funct7 are architecturally ignored.
    assign unused_bits = ^{bus.i_func[9:3], eff[31:WIDTH+2]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            bus.o_valid <= 1'b0;
            bus.o_data  <= '0;
            bus.o_addr  <= '0;
        end else begin
            if (wr_en) begin
                mem[widx] <= wr_word;
            end
            bus.o_valid <= ld_en;
            if (ld_en) begin
                bus.o_data <= ld_res;
                bus.o_addr <= bus.i_addr;
            end
        end
    end
endmodule

// File: tb/tb_mem_calc.sv
// Randomized and directed bench for mem_calc against a byte-array reference memory.
// The driver queues one expectation per cycle; a negedge monitor pops and compares.
module tb_mem_calc;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    typedef struct {
        bit          rst;
        bit          vld;
        logic [31:0] data;
        logic [6:0]  tag;
    } exp_t;

    logic i_clk;
    logic i_rst;
    mem_calc_if #(.WIDTH_REG(7)) bus ();

    mem_calc #(.WIDTH(4), .WIDTH_REG(7)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    exp_t        sb[$];
    logic [7:0]  mem_b [64];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] hold_d = '0;
    logic [6:0]  hold_a = '0;
    exp_t        cur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [5:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        logic [5:0]  hb;
        logic [5:0]  wb;
        hb = {a[5:1], 1'b0};
        wb = {a[5:2], 2'b00};
        b  = mem_b[a];
        h  = {mem_b[hb + 6'd1], mem_b[hb]};
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'h0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'h0, h};
            3'd2:    return {mem_b[wb + 6'd3], mem_b[wb + 6'd2], mem_b[wb + 6'd1], mem_b[wb]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic drive(input bit rst, input bit vld, input logic [6:0] uop, input logic [2:0] f3,
                         input logic [6:0] rd, input logic [31:0] op1, input logic [31:0] op2,
                         input logic [31:0] imm);
        exp_t        e;
        logic [31:0] eff;
        logic [5:0]  a;
        logic [5:0]  base;
        i_rst       = rst;
        bus.i_valid = vld;
        bus.i_uop   = uop;
        bus.i_func  = {7'($urandom), f3};
        bus.i_addr  = rd;
        bus.i_op1   = op1;
        bus.i_op2   = op2;
        bus.i_imm   = imm;
        eff = op1 + imm;
        a   = eff[5:0];
        e.rst  = rst;
        e.vld  = 1'b0;
        e.data = '0;
        e.tag  = '0;
        if (rst) begin
            for (int i = 0; i < 64; i++) mem_b[i] = 8'h00;
        end else if (vld && uop == STORE) begin
            case (f3)
                3'd0: mem_b[a] = op2[7:0];
                3'd1: begin
                    base = {a[5:1], 1'b0};
                    mem_b[base]        = op2[7:0];
                    mem_b[base + 6'd1] = op2[15:8];
                end
                3'd2: begin
                    base = {a[5:2], 2'b00};
                    for (int k = 0; k < 4; k++) mem_b[base + 6'(k)] = op2[8*k +: 8];
                end
                default: ;
            endcase
        end else if (vld && uop == LOAD) begin
            e.vld  = 1'b1;
            e.tag  = rd;
            e.data = model_load(f3, a);
        end
        sb.push_back(e);
        @(posedge i_clk);
        #1;
    endtask

    always @(negedge i_clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            if (cur.rst) begin
                hold_d = '0;
                hold_a = '0;
            end
            check("o_valid", {31'h0, bus.o_valid}, {31'h0, cur.vld});
            if (cur.vld) begin
                hold_d = cur.data;
                hold_a = cur.tag;
            end
            check("o_data", bus.o_data, hold_d);
            check("o_addr", {25'h0, bus.o_addr}, {25'h0, hold_a});
        end
    end

    initial begin
        logic [6:0] uop;
        int         sel;
        for (int i = 0; i < 64; i++) mem_b[i] = 8'h00;

        drive(1, 1, STORE, 3'd2, 7'd0, 32'h0, 32'hFFFFFFFF, 32'h0);
        drive(1, 0, 7'd0,  3'd0, 7'd0, 32'h0, 32'h0, 32'h0);

        // SB to eff=2, then LW of the same word in the next cycle
        drive(0, 1, STORE, 3'd0, 7'd3, 32'd1, 32'd3, 32'd1);
        drive(0, 1, LOAD,  3'd2, 7'd3, 32'd1, 32'd0, 32'd1);
        drive(0, 1, 7'd0,  3'd0, 7'd5, 32'd2, 32'd4, 32'd3);
        drive(0, 0, LOAD,  3'd2, 7'd6, 32'd0, 32'd0, 32'd0);
        drive(0, 1, LOAD,  3'd2, 7'd7, 32'd0, 32'd0, 32'd0);

        drive(0, 1, STORE, 3'd2, 7'd0,  32'd8, 32'h80FF7F01, 32'd0);
        drive(0, 1, LOAD,  3'd0, 7'd10, 32'd8, 32'd0, 32'd0);
        drive(0, 1, LOAD,  3'd0, 7'd11, 32'd8, 32'd0, 32'd1);
        drive(0, 1, LOAD,  3'd4, 7'd12, 32'd8, 32'd0, 32'd2);
        drive(0, 1, LOAD,  3'd0, 7'd13, 32'd8, 32'd0, 32'd3);
        drive(0, 1, LOAD,  3'd1, 7'd14, 32'd8, 32'd0, 32'd2);
        drive(0, 1, LOAD,  3'd5, 7'd15, 32'd8, 32'd0, 32'd2);
        drive(0, 1, LOAD,  3'd3, 7'd16, 32'd8, 32'd0, 32'd0);

        // Aliasing above the memory and a negative immediate
        drive(0, 1, STORE, 3'd2, 7'd0,  32'h40, 32'hDEADBEEF, 32'h4);
        drive(0, 1, LOAD,  3'd2, 7'd20, 32'h0,  32'd0, 32'h4);
        drive(0, 1, STORE, 3'd1, 7'd0,  32'h10, 32'h1234ABCD, 32'hFFFFFFFC);
        drive(0, 1, LOAD,  3'd2, 7'd21, 32'h10, 32'd0, 32'hFFFFFFFC);

        // Reset dominates a store presented in the same cycle
        drive(0, 1, STORE, 3'd2, 7'd0,  32'h20, 32'hCAFEF00D, 32'h0);
        drive(1, 1, STORE, 3'd2, 7'd0,  32'h20, 32'h55AA55AA, 32'h0);
        drive(1, 1, LOAD,  3'd2, 7'd22, 32'h20, 32'd0, 32'h0);
        drive(0, 1, LOAD,  3'd2, 7'd23, 32'h20, 32'd0, 32'h0);
        drive(0, 1, LOAD,  3'd2, 7'd24, 32'h8,  32'd0, 32'h0);

        for (int n = 0; n < 600; n++) begin
            sel = int'($urandom_range(0, 9));
            uop = (sel < 4) ? STORE : (sel < 8) ? LOAD : 7'($urandom);
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0), uop,
                  3'($urandom), 7'($urandom), $urandom,
                  $urandom, (sel[0] ? 32'($urandom_range(0, 80)) : $urandom));
        end

        drive(0, 0, 7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0);
        drive(0, 0, 7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0);
        repeat (2) @(negedge i_clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
